// File: rtl/ay_bus_sequencer.sv
// AY-3-8913 bus sequencer: FIFO of {reg,data} writes drained onto BDIR/BC1/DA
// as latch-address then write phases, with inactive bus cycles between them.
// Ports: clk, reset (async, active-high)
//        in_valid/in_ready/in_reg/in_data : request push port
//        invalidate : drop the remembered latched register
//        bdir/bc1/da : registered PSG bus; busy, count : status
module ay_bus_sequencer #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [3:0] CHIP_ADDR    = 4'b0000,
  parameter int         PHASE_CYCLES = 2,
  parameter bit         SKIP_RELATCH = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  in_reg,
  input  logic [7:0]                  in_data,
  input  logic                        invalidate,
  output logic                        bdir,
  output logic                        bc1,
  output logic [7:0]                  da,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] PH_LAST = 4'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP1,
    S_WRITE,
    S_GAP2
  } state_t;

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] sel_ptr;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          lv_q, lv_d;
  logic [3:0]    lr_q, lr_d;

  logic          bdir_q, bdir_d;
  logic          bc1_q, bc1_d;
  logic [7:0]    da_q, da_d;

  logic          push;
  logic          pop;
  logic          skip;
  logic [3:0]    h_reg;
  logic [7:0]    h_data;

  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign count    = count_q;
  assign busy     = (count_q != '0) || (state_q != S_IDLE);
  assign bdir     = bdir_q;
  assign bc1      = bc1_q;
  assign da       = da_q;

  // In GAP2 the head is popped at the coming edge, so the decision for
  // the next entry must already look one slot ahead.
  assign sel_ptr = (state_q == S_GAP2) ? rd_q + AW'(1) : rd_q;
  assign {h_reg, h_data} = mem_q[sel_ptr];

  assign skip = SKIP_RELATCH && lv_q && (h_reg == lr_q);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {in_reg, in_data};
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pop     = 1'b0;
    lv_d    = lv_q;
    lr_d    = lr_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = skip ? S_WRITE : S_LATCH;
        end
      end
      S_LATCH: begin
        if (cnt_q == PH_LAST) begin
          state_d = S_GAP1;
          lv_d    = 1'b1;
          lr_d    = h_reg;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP1: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (cnt_q == PH_LAST) begin
          state_d = S_GAP2;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP2: begin
        pop = 1'b1;
        if (count_q > CW'(1)) begin
          state_d = skip ? S_WRITE : S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Invalidate has priority over the latch-exit update.
    if (invalidate) begin
      lv_d = 1'b0;
    end
  end

  // Bus values are derived from the next state so the pins change on
  // the same edge the FSM enters a phase.
  always_comb begin
    bdir_d = 1'b0;
    bc1_d  = 1'b0;
    da_d   = 8'h00;
    unique case (state_d)
      S_LATCH: begin
        bdir_d = 1'b1;
        bc1_d  = 1'b1;
        da_d   = {CHIP_ADDR, h_reg};
      end
      S_WRITE: begin
        bdir_d = 1'b1;
        da_d   = h_data;
      end
      S_GAP1, S_GAP2: begin
        da_d = da_q;
      end
      default: begin
        da_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lv_q    <= 1'b0;
      lr_q    <= '0;
      bdir_q  <= 1'b0;
      bc1_q   <= 1'b0;
      da_q    <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lv_q    <= lv_d;
      lr_q    <= lr_d;
      bdir_q  <= bdir_d;
      bc1_q   <= bc1_d;
      da_q    <= da_d;
    end
  end

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// Bench for ay_bus_sequencer: directed vectors, PSG register model,
// parameter variants for phase length and chip address.
module tb_ay_bus_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [3:0] in_reg = '0;
  logic [7:0] in_data = '0;
  logic invalidate = 1'b0;

  logic rdy0, rdy1, rdy2;
  logic bdir0, bdir1, bdir2;
  logic bc10, bc11, bc12;
  logic [7:0] da0, da1, da2;
  logic busy0, busy1, busy2;
  logic [2:0] cnt0, cnt1, cnt2;

  int checks = 0;
  int failures = 0;
  int busy_cyc = 0;

  always #5 clk = ~clk;

  ay_bus_sequencer u0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0),
    .in_reg(in_reg), .in_data(in_data), .invalidate(invalidate),
    .bdir(bdir0), .bc1(bc10), .da(da0), .busy(busy0), .count(cnt0)
  );

  ay_bus_sequencer #(.PHASE_CYCLES(1), .CHIP_ADDR(4'hA)) u1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1),
    .in_reg(in_reg), .in_data(in_data), .invalidate(invalidate),
    .bdir(bdir1), .bc1(bc11), .da(da1), .busy(busy1), .count(cnt1)
  );

  ay_bus_sequencer #(.PHASE_CYCLES(15), .CHIP_ADDR(4'hA)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
    .in_reg(in_reg), .in_data(in_data), .invalidate(invalidate),
    .bdir(bdir2), .bc1(bc12), .da(da2), .busy(busy2), .count(cnt2)
  );

  // PSG models: 0 on u0 (mask 0), 1 on u1 (mask A), 2 on u1 (mask 0),
  // 3 on u2 (mask A). A write commits when the write pulse ends.
  logic [7:0] m_regs [4][16];
  logic       m_sel  [4];
  logic [3:0] m_addr [4];
  logic       m_pend [4];
  logic [7:0] m_pd   [4];
  bit         m_init = 1'b0;

  function automatic logic [3:0] mask_of(int i);
    return (i == 1 || i == 3) ? 4'hA : 4'h0;
  endfunction

  task automatic psg_step(int i, logic b, logic c, logic [7:0] d);
    if (b && c) begin
      m_sel[i]  = (d[7:4] == mask_of(i));
      m_addr[i] = d[3:0];
    end else if (b && !c) begin
      if (m_sel[i]) begin
        m_pend[i] = 1'b1;
        m_pd[i]   = d;
      end
    end else if (!b && !c && m_pend[i]) begin
      m_regs[i][m_addr[i]] = m_pd[i];
      m_pend[i] = 1'b0;
    end
  endtask

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        if (!m_init) begin
          for (int j = 0; j < 16; j++) m_regs[i][j] = 8'h00;
          m_addr[i] = 4'h0;
          m_pd[i]   = 8'h00;
        end
        m_sel[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end
      m_init = 1'b1;
    end else begin
      psg_step(0, bdir0, bc10, da0);
      psg_step(1, bdir1, bc11, da1);
      psg_step(2, bdir1, bc11, da1);
      psg_step(3, bdir2, bc12, da2);
    end
  end

  always @(negedge clk) begin
    if (busy0) busy_cyc++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Check the bus now, then drive invalidate for the next edge and advance.
  task automatic exp_bus(string nm, logic [1:0] bc, logic [7:0] d, bit inv);
    chk(nm, {22'd0, bdir0, bc10, da0}, {22'd0, bc, d});
    invalidate = inv;
    @(negedge clk);
    invalidate = 1'b0;
  endtask

  task automatic entry_seq(string nm, logic [3:0] r, logic [7:0] d,
                           bit latch, int inv_idx);
    int s = 0;
    if (latch) begin
      for (int i = 0; i < 2; i++) begin
        exp_bus({nm, "_latch"}, 2'b11, {4'h0, r}, s == inv_idx);
        s++;
      end
      exp_bus({nm, "_gap1"}, 2'b00, {4'h0, r}, s == inv_idx);
      s++;
    end
    for (int i = 0; i < 2; i++) begin
      exp_bus({nm, "_write"}, 2'b10, d, s == inv_idx);
      s++;
    end
    exp_bus({nm, "_gap2"}, 2'b00, d, s == inv_idx);
  endtask

  task automatic idle_chk(string nm);
    chk({nm, "_idle_bus"}, {23'd0, bdir0, bc10, da0}, 32'd0);
    chk({nm, "_idle_busy"}, {31'd0, busy0}, 32'd0);
  endtask

  task automatic apply_single(string nm, logic [3:0] r, logic [7:0] d,
                              bit inv, bit latch);
    if (inv) begin
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
    end
    v0 = 1'b1; in_reg = r; in_data = d;
    @(negedge clk);
    v0 = 1'b0;
    chk({nm, "_busy_after_push"}, {31'd0, busy0}, 32'd1);
    chk({nm, "_bus_after_push"}, {22'd0, bdir0, bc10, da0}, 32'd0);
    chk({nm, "_count_after_push"}, {29'd0, cnt0}, 32'd1);
    @(negedge clk);
    entry_seq(nm, r, d, latch, -1);
    idle_chk(nm);
    chk({nm, "_psg"}, {24'd0, m_regs[0][r]}, {24'd0, d});
  endtask

  task automatic push2(logic [3:0] r1, logic [7:0] d1,
                       logic [3:0] r2, logic [7:0] d2);
    v0 = 1'b1; in_reg = r1; in_data = d1;
    @(negedge clk);
    in_reg = r2; in_data = d2;
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic measure(string nm, int which, logic [3:0] r,
                         logic [7:0] d, int ph);
    int n11 = 0;
    int n10 = 0;
    int bad = 0;
    bit done = 1'b0;
    logic b, c, bz;
    logic [7:0] dd;
    in_reg = r; in_data = d;
    if (which == 1) v1 = 1'b1;
    else v2 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      b  = (which == 1) ? bdir1 : bdir2;
      c  = (which == 1) ? bc11 : bc12;
      bz = (which == 1) ? busy1 : busy2;
      dd = (which == 1) ? da1 : da2;
      if (!bz) begin
        done = 1'b1;
        break;
      end
      if (b && c) begin
        n11++;
        if (dd != {4'hA, r}) bad++;
      end
      if (b && !c) begin
        n10++;
        if (dd != d) bad++;
      end
      @(negedge clk);
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_latch_len"}, n11, ph);
    chk({nm, "_write_len"}, n10, ph);
    chk({nm, "_da_values"}, bad, 0);
  endtask

  typedef struct {
    logic [3:0] r;
    logic [7:0] d;
    bit         inv;
    bit         latch;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int acc;
    bit rdy;
    bit found;

    tbl[0] = '{4'd7,  8'h38, 1'b0, 1'b1};
    tbl[1] = '{4'd7,  8'h55, 1'b0, 1'b0};
    tbl[2] = '{4'd7,  8'h11, 1'b1, 1'b1};
    tbl[3] = '{4'd3,  8'hA5, 1'b0, 1'b1};
    tbl[4] = '{4'd3,  8'h00, 1'b0, 1'b0};
    tbl[5] = '{4'd15, 8'hFF, 1'b0, 1'b1};
    tbl[6] = '{4'd6,  8'h66, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_bus", {22'd0, bdir0, bc10, da0}, 32'd0);
    chk("reset_count", {29'd0, cnt0}, 32'd0);
    chk("reset_ready", {31'd0, rdy0}, 32'd1);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply_single($sformatf("vec%0d", i), tbl[i].r, tbl[i].d,
                   tbl[i].inv, tbl[i].latch);
    end

    // Same register back to back: second entry skips the latch.
    push2(4'd8, 8'h0F, 4'd8, 8'h05);
    entry_seq("skip_a", 4'd8, 8'h0F, 1'b1, -1);
    entry_seq("skip_b", 4'd8, 8'h05, 1'b0, -1);
    idle_chk("skip");
    chk("skip_psg", {24'd0, m_regs[0][8]}, 32'h05);

    // Invalidate during the first write: second entry re-latches.
    push2(4'd9, 8'h0F, 4'd9, 8'h05);
    entry_seq("inv_a", 4'd9, 8'h0F, 1'b1, 3);
    entry_seq("inv_b", 4'd9, 8'h05, 1'b1, -1);
    idle_chk("inv");

    // Invalidate on the latch-exit cycle still forces a re-latch.
    push2(4'd10, 8'h11, 4'd10, 8'h22);
    entry_seq("invx_a", 4'd10, 8'h11, 1'b1, 1);
    entry_seq("invx_b", 4'd10, 8'h22, 1'b1, -1);
    idle_chk("invx");
    chk("invx_psg", {24'd0, m_regs[0][10]}, 32'h22);

    // Full FIFO with in_valid held over regs 0..5.
    acc = 0;
    busy_cyc = 0;
    for (int k = 0; k < 60 && acc < 6; k++) begin
      v0 = 1'b1; in_reg = 4'(acc); in_data = 8'(8'h20 + acc);
      rdy = rdy0;
      if (k >= 4 && k <= 7) chk($sformatf("full_ready_k%0d", k), {31'd0, rdy}, 32'd0);
      if (k == 7) chk("full_accepted", acc, 4);
      if (k == 8) chk("full_ready_after_pop", {31'd0, rdy}, 32'd1);
      @(negedge clk);
      if (rdy) acc++;
    end
    v0 = 1'b0;
    chk("full_all_pushed", acc, 6);
    for (int w = 0; w < 200 && busy0; w++) @(negedge clk);
    chk("full_drained", {31'd0, busy0}, 32'd0);
    chk("full_busy_cycles", busy_cyc, 37);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("full_psg_r%0d", i), {24'd0, m_regs[0][i]}, 32'h20 + i);
    end

    // Reset in the middle of a write phase.
    v0 = 1'b1; in_reg = 4'd6; in_data = 8'h77;
    @(negedge clk);
    v0 = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (bdir0 && !bc10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_write_seen", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_bus", {22'd0, bdir0, bc10, da0}, 32'd0);
    chk("rst_count", {29'd0, cnt0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_psg_unchanged", {24'd0, m_regs[0][6]}, 32'h66);
    apply_single("post_rst", 4'd6, 8'h99, 1'b0, 1'b1);

    // Parameter variants with chip address A.
    measure("ph1", 1, 4'd2, 8'h5A, 1);
    chk("ph1_psg_match", {24'd0, m_regs[1][2]}, 32'h5A);
    chk("ph1_psg_nomatch", {24'd0, m_regs[2][2]}, 32'h00);
    measure("ph15", 2, 4'd4, 8'hC3, 15);
    chk("ph15_psg_match", {24'd0, m_regs[3][4]}, 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
